// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then frames header/payload/parity onto the router byte interface
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic       corrupt_parity,
  output logic       start_ready,
  output logic       req_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_done
);
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] addr, addr_n;
  logic [5:0] len, len_n, wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  logic       corrupt, corrupt_n;
  logic [7:0] par, par_n, gap_cnt, gap_cnt_n, data_n, hdr, par_out;
  logic       pkt_valid_n, req_err_n, tx_done_n;
  logic [7:0] mem [MAX_LEN];
  assign start_ready = state == IDLE;
  assign pl_ready    = state == LOAD;
  assign hdr         = {len, addr};
  assign par_out     = par ^ {8{corrupt}};
  // payload buffer fill; contents need no reset since every byte is written before it is read
  always_ff @(posedge clk)
    if (pl_ready && pl_valid) mem[wr_cnt] <= pl_data;
  // state, capture and registered output flops
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      corrupt   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      par       <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      req_err   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      len       <= len_n;
      corrupt   <= corrupt_n;
      wr_cnt    <= wr_cnt_n;
      rd_cnt    <= rd_cnt_n;
      par       <= par_n;
      gap_cnt   <= gap_cnt_n;
      data_out  <= data_n;
      pkt_valid <= pkt_valid_n;
      req_err   <= req_err_n;
      tx_done   <= tx_done_n;
    end
  end
  // next-state and next-output decode; every transmit step waits for busy=0
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    len_n       = len;
    corrupt_n   = corrupt;
    wr_cnt_n    = wr_cnt;
    rd_cnt_n    = rd_cnt;
    par_n       = par;
    gap_cnt_n   = gap_cnt;
    data_n      = data_out;
    pkt_valid_n = pkt_valid;
    req_err_n   = 1'b0;
    tx_done_n   = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (dest_addr == 2'd3) req_err_n = 1'b1;
        else begin
          addr_n    = dest_addr;
          len_n     = pay_len;
          corrupt_n = corrupt_parity;
          wr_cnt_n  = '0;
          rd_cnt_n  = '0;
          if (pay_len == 6'd0) begin
            state_n     = HEADER;
            data_n      = {pay_len, dest_addr};
            par_n       = {pay_len, dest_addr};
            pkt_valid_n = 1'b1;
          end else state_n = LOAD;
        end
      end
      LOAD: if (pl_valid) begin
        wr_cnt_n = wr_cnt + 6'd1;
        if (wr_cnt == len - 6'd1) begin
          state_n     = HEADER;
          data_n      = hdr;
          par_n       = hdr;
          pkt_valid_n = 1'b1;
        end
      end
      HEADER: if (!busy) begin
        if (len == 6'd0) begin
          state_n     = PARITY;
          data_n      = par_out;
          pkt_valid_n = 1'b0;
        end else begin
          state_n  = PAYLOAD;
          data_n   = mem[0];
          par_n    = par ^ mem[0];
          rd_cnt_n = 6'd1;
        end
      end
      PAYLOAD: if (!busy) begin
        if (rd_cnt == len) begin
          state_n     = PARITY;
          data_n      = par_out;
          pkt_valid_n = 1'b0;
        end else begin
          data_n   = mem[rd_cnt];
          par_n    = par ^ mem[rd_cnt];
          rd_cnt_n = rd_cnt + 6'd1;
        end
      end
      PARITY: if (!busy) begin
        state_n   = GAP;
        data_n    = '0;
        tx_done_n = 1'b1;
        gap_cnt_n = '0;
      end
      GAP: begin
        gap_cnt_n = gap_cnt + 8'd1;
        state_n   = gap_cnt == GAP_LAST ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: queue-based packet model with per-cycle output compare plus pinned literal packets
module tb_router_pkt_tx;
  localparam int GAP = 2;
  logic       clk = 1'b0;
  logic       rstn, start, corrupt_parity, pl_valid, busy;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pl_data, data_out;
  logic       start_ready, req_err, pl_ready, pkt_valid, tx_done;
  int checks = 0, failures = 0;
  int m_phase = 0, need = 0, gap_left = 0;
  int hold22 = 0, nerr = 0, ndone = 0, nplr = 0;
  bit armed = 0, exp_err = 0, exp_done = 0, m_cor = 0;
  logic [1:0] m_addr;
  logic [5:0] m_len;
  logic [7:0] pay_q[$];
  logic [8:0] q[$];
  logic [8:0] seen[$];
  logic [7:0] pay [64];

  router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .corrupt_parity(corrupt_parity), .start_ready(start_ready), .req_err(req_err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task build_q();
    logic [7:0] p;
    p = {m_len, m_addr};
    q.delete();
    q.push_back({1'b1, p});
    foreach (pay_q[i]) begin
      q.push_back({1'b1, pay_q[i]});
      p ^= pay_q[i];
    end
    q.push_back({1'b0, p ^ (m_cor ? 8'hFF : 8'h00)});
  endtask

  // packet-level model: collect payload, then the expected byte stream drains one entry per non-busy edge
  always @(posedge clk) begin
    exp_err  = 0;
    exp_done = 0;
    if (!rstn) begin
      armed   = 1;
      m_phase = 0;
      q.delete();
    end else case (m_phase)
      0: if (start) begin
        if (dest_addr == 2'd3) exp_err = 1;
        else begin
          m_addr = dest_addr;
          m_len  = pay_len;
          m_cor  = corrupt_parity;
          pay_q.delete();
          need = int'(pay_len);
          if (need == 0) begin build_q(); m_phase = 2; end
          else m_phase = 1;
        end
      end
      1: if (pl_valid) begin
        pay_q.push_back(pl_data);
        need--;
        if (need == 0) begin build_q(); m_phase = 2; end
      end
      2: if (!busy) begin
        void'(q.pop_front());
        if (q.size() == 0) begin exp_done = 1; m_phase = 3; gap_left = GAP; end
      end
      default: begin
        gap_left--;
        if (gap_left == 0) m_phase = 0;
      end
    endcase
  end

  // per-cycle compare against the model
  always @(negedge clk) if (armed) begin
    chk("start_ready", start_ready, m_phase == 0);
    chk("pl_ready", pl_ready, m_phase == 1);
    chk("req_err", req_err, exp_err);
    chk("tx_done", tx_done, exp_done);
    if (m_phase == 2) begin
      chk("data_out", data_out, q[0][7:0]);
      chk("pkt_valid", pkt_valid, q[0][8]);
      if (!busy) seen.push_back({pkt_valid, data_out});
    end else begin
      chk("idle_data", data_out, 0);
      chk("idle_valid", pkt_valid, 0);
    end
    if (pkt_valid && data_out == 8'h22) hold22++;
    if (req_err) nerr++;
    if (tx_done) ndone++;
    if (pl_ready) nplr++;
  end

  task automatic req(input logic [1:0] a, input logic [5:0] l, input logic c);
    start = 1; dest_addr = a; pay_len = l; corrupt_parity = c;
    @(posedge clk); #1;
    start = 0; corrupt_parity = 0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int i = 0;
    for (int k = 0; i < n && k < 1000; k++) begin
      pl_valid = !toggle || (k % 2 == 1);
      pl_data  = pay[i];
      @(posedge clk); #1;
      if (pl_valid) i++;
    end
    pl_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_phase != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", m_phase == 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rstn = 0; start = 0; dest_addr = 0; pay_len = 0; corrupt_parity = 0;
    pl_data = 0; pl_valid = 0; busy = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);
    @(posedge clk); #1;
    // basic
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    seen.delete(); ndone = 0;
    req(2'd1, 6'd3, 1'b0);
    feed(3, 0);
    wait_idle();
    chk("basic_len", seen.size(), 5);
    if (seen.size() == 5) begin
      chk("basic_hdr", seen[0], 9'h10D);
      chk("basic_b0", seen[1], 9'h111);
      chk("basic_b1", seen[2], 9'h122);
      chk("basic_b2", seen[3], 9'h133);
      chk("basic_par", seen[4], 9'h00D);
    end
    chk("basic_done", ndone, 1);
    // stall on byte 22, with a stray illegal start that must be ignored
    seen.delete(); hold22 = 0; nerr = 0;
    req(2'd1, 6'd3, 1'b0);
    feed(3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    busy = 1; start = 1; dest_addr = 2'd3;
    repeat (3) begin @(posedge clk); #1; end
    busy = 0; start = 0; dest_addr = 0;
    wait_idle();
    chk("stall_hold22", hold22, 4);
    chk("stall_noerr", nerr, 0);
    chk("stall_len", seen.size(), 5);
    if (seen.size() == 5) begin
      chk("stall_b1", seen[2], 9'h122);
      chk("stall_par", seen[4], 9'h00D);
    end
    // corrupt parity, zero length
    seen.delete(); nplr = 0;
    req(2'd2, 6'd0, 1'b1);
    wait_idle();
    chk("zero_len", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("zero_hdr", seen[0], 9'h102);
      chk("zero_par", seen[1], 9'h0FD);
    end
    chk("zero_pl_ready", nplr, 0);
    // illegal address
    nerr = 0;
    req(2'd3, 6'd5, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("illegal_err_pulses", nerr, 1);
    chk("illegal_idle", start_ready, 1);
    // max length with toggling pl_valid
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    seen.delete();
    req(2'd0, 6'd63, 1'b0);
    feed(63, 1);
    wait_idle();
    chk("max_len", seen.size(), 65);
    if (seen.size() == 65) begin
      chk("max_hdr", seen[0], 9'h1FC);
      for (int i = 0; i < 63; i++) chk("max_byte", seen[i + 1], {1'b1, 8'(i)});
      chk("max_par", seen[64], 9'h0C3);
    end
    // reset in the middle of loading
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'h40 + i);
    req(2'd1, 6'd10, 1'b0);
    feed(5, 0);
    pl_valid = 1; pl_data = pay[5]; rstn = 0;
    @(posedge clk); #1;
    rstn = 1; pl_valid = 0;
    @(negedge clk);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_valid", pkt_valid, 0);
    chk("midrst_ready", start_ready, 1);
    pay[0] = 8'hAA; pay[1] = 8'h55;
    seen.delete();
    req(2'd1, 6'd2, 1'b0);
    feed(2, 0);
    wait_idle();
    chk("post_len", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("post_hdr", seen[0], 9'h109);
      chk("post_b0", seen[1], 9'h1AA);
      chk("post_b1", seen[2], 9'h155);
      chk("post_par", seen[3], 9'h0F6);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
